// File: rtl/mp_add_seq_if.sv
// Request/result bundle for the multi-precision add/subtract sequencer.
// Both sides use valid/ready handshakes; operands and result are 32*WORDS bits wide.
interface mp_add_seq_if #(
  parameter int WORDS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [32*WORDS-1:0]   op_a;
  logic [32*WORDS-1:0]   op_b;
  logic                  sub;
  logic                  out_valid;
  logic                  out_ready;
  logic [32*WORDS-1:0]   result;
  logic                  carry_out;
  logic                  overflow;

  modport master (
    output in_valid, op_a, op_b, sub, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow
  );

  modport slave (
    input  in_valid, op_a, op_b, sub, out_ready,
    output in_ready, out_valid, result, carry_out, overflow
  );
endinterface

// File: rtl/mp_add_seq.sv
// Multi-precision add/sub, one 32-bit limb per cycle through a shared adder; result valid WORDS+1 cycles after accept.
// Backpressure: the result holds in DONE until out_ready; new requests wait (in_ready=0) until the sequencer is idle.
module adder_32bits (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {32'b0, ci};
endmodule

module mp_add_seq #(
  parameter int WORDS = 4
) (
  input logic          clk,
  input logic          rst_n,
  mp_add_seq_if.slave  bus
);
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]             state;
  logic [WORDS-1:0][31:0] a_q;
  logic [WORDS-1:0][31:0] b_q;
  logic [WORDS-1:0][31:0] res_q;
  logic                   sub_q;
  logic                   carry_q;
  logic                   co_q;
  logic                   ov_q;
  logic [IDXW-1:0]        idx;

  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_s;
  logic        add_ci;
  logic        add_co;
  logic        last;

  assign add_a  = a_q[idx];
  assign add_b  = b_q[idx];
  // Subtract is a + ~b + 1: the +1 enters as the carry-in of limb 0.
  assign add_ci = (idx == '0) ? sub_q : carry_q;
  assign last   = (idx == IDXW'(WORDS - 1));

  adder_32bits u_adder (
    .a  (add_a),
    .b  (add_b),
    .ci (add_ci),
    .s  (add_s),
    .co (add_co)
  );

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.result    = res_q;
  assign bus.carry_out = co_q;
  assign bus.overflow  = ov_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      idx     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.op_a;
            b_q   <= bus.sub ? ~bus.op_b : bus.op_b;
            sub_q <= bus.sub;
            idx   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          res_q[idx] <= add_s;
          carry_q    <= add_co;
          if (last) begin
            co_q  <= add_co;
            ov_q  <= (add_a[31] == add_b[31]) & (add_s[31] != add_a[31]);
            idx   <= '0;
            state <= ST_DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        ST_DONE: begin
          if (bus.out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mp_add_seq.sv
// Directed bench for mp_add_seq (WORDS=4): carry chains, subtract, overflow, backpressure, reset.
module tb_mp_add_seq;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  mp_add_seq_if #(.WORDS(W)) bus ();

  mp_add_seq #(.WORDS(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Issue one request, wait for the result (holding out_ready low), then consume it.
  task automatic run_op(input logic [127:0] a, input logic [127:0] b, input logic s,
                        output logic [127:0] res, output logic co, output logic ov,
                        output int lat);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op_a = a;
    bus.op_b = b;
    bus.sub = s;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op_a = ~a;
    bus.op_b = ~b;
    bus.sub = ~s;
    lat = 0;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
    end
    res = bus.result;
    co = bus.carry_out;
    ov = bus.overflow;
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
    end
    n_checks++;
    if (bus.result !== 128'd0 || bus.carry_out !== 1'b0 || bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: result=%h co=%b ov=%b required 0/0/0", bus.result, bus.carry_out, bus.overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_carry_wrap();
    logic [127:0] r; logic co, ov; int lat;
    run_op({128{1'b1}}, 128'd1, 1'b0, r, co, ov, lat);
    n_checks++;
    if (lat !== 5) begin
      n_fail++;
      $display("FAIL wrap_latency: got %0d required 5", lat);
    end
    n_checks++;
    if (r !== 128'd0 || co !== 1'b1 || ov !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_value: result=%h co=%b ov=%b required 0/1/0", r, co, ov);
    end
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_idle: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_cross_limb();
    logic [127:0] r; logic co, ov; int lat;
    run_op(128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, 1'b0, r, co, ov, lat);
    n_checks++;
    if (r !== 128'h00000001_00000000_00000000_00000000 || co !== 1'b0 || ov !== 1'b0) begin
      n_fail++;
      $display("FAIL cross_limb: result=%h co=%b ov=%b required 00000001_0..0/0/0", r, co, ov);
    end
  endtask

  task automatic test_sub_borrow();
    logic [127:0] r; logic co, ov; int lat;
    run_op(128'd0, 128'd1, 1'b1, r, co, ov, lat);
    n_checks++;
    if (r !== {128{1'b1}} || co !== 1'b0 || ov !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_borrow: result=%h co=%b ov=%b required all-ones/0/0", r, co, ov);
    end
    run_op(128'd5, 128'd3, 1'b1, r, co, ov, lat);
    n_checks++;
    if (r !== 128'd2 || co !== 1'b1 || ov !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_5_3: result=%h co=%b ov=%b required 2/1/0", r, co, ov);
    end
  endtask

  task automatic test_overflow();
    logic [127:0] r; logic co, ov; int lat;
    run_op(128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, 1'b0, r, co, ov, lat);
    n_checks++;
    if (r !== 128'h80000000_00000000_00000000_00000000 || co !== 1'b0 || ov !== 1'b1) begin
      n_fail++;
      $display("FAIL add_overflow: result=%h co=%b ov=%b required 8000..0/0/1", r, co, ov);
    end
    // Most negative minus one wraps to most positive.
    run_op(128'h80000000_00000000_00000000_00000000, 128'd1, 1'b1, r, co, ov, lat);
    n_checks++;
    if (r !== 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF || co !== 1'b1 || ov !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_overflow: result=%h co=%b ov=%b required 7FFF..F/1/1", r, co, ov);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op_a = 128'd10;
    bus.op_b = 128'd20;
    bus.sub = 1'b0;
    @(posedge clk);
    #1;
    bus.op_a = 128'd7;
    bus.op_b = 128'd8;
    lat = 0;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
    end
    n_checks++;
    if (lat !== 5) begin
      n_fail++;
      $display("FAIL bp_latency: got %0d required 5", lat);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== 128'd30 ||
          bus.carry_out !== 1'b0 || bus.overflow !== 1'b0) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL bp_hold: %0d unstable cycles required 0 (result=%h)", bad, bus.result);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
    end
    n_checks++;
    if (lat !== 5 || bus.result !== 128'd15) begin
      n_fail++;
      $display("FAIL bp_pending: latency=%0d result=%h required 5/15", lat, bus.result);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [127:0] r; logic co, ov; int lat;
    int stale;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op_a = {128{1'b1}};
    bus.op_b = 128'd1;
    bus.sub = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== 128'd0 || bus.carry_out !== 1'b0 ||
        bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: out_valid=%b result=%h co=%b in_ready=%b required 0/0/0/1",
               bus.out_valid, bus.result, bus.carry_out, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) stale++;
    end
    n_checks++;
    if (stale !== 0) begin
      n_fail++;
      $display("FAIL reset_stale: %0d cycles with out_valid or in_ready wrong, required 0", stale);
    end
    run_op(128'h00000002_00000000_00000000_00000003, 128'h00000001_00000000_00000000_00000004,
           1'b0, r, co, ov, lat);
    n_checks++;
    if (r !== 128'h00000003_00000000_00000000_00000007 || co !== 1'b0 || lat !== 5) begin
      n_fail++;
      $display("FAIL reset_recover: result=%h co=%b latency=%0d required 3_0_0_7/0/5", r, co, lat);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.sub = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_carry_wrap();
    test_cross_limb();
    test_sub_borrow();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
